id_ex_stage: RTL

//  ID/EX pipeline register with load-use hazard detection and bubble insertion. Captures decoded

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Pipeline-wide constants shared by the decode/execute boundary: widths, the x0 index,
// bubble field values and the EX-register update actions.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int CSR_AW   = 12;
    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 5;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    // Write enables are active-low, so a bubble drives them high.
    localparam logic BUBBLE_WB_N      = 1'b1;
    localparam logic BUBBLE_CSR_WEN_N = 1'b1;

    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_CAPTURE = 2'd2
    } ex_action_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: the load in EX writes a register the ID instruction reads.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_wb,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    output logic              hazard
);

    logic ex_is_load_wb;
    logic src_match;

    // ex_wb is active-low; a load into x0 never produces a value worth waiting for.
    assign ex_is_load_wb = ex_valid & ex_mem_read & ~ex_wb & (ex_rd != REG_X0);
    assign src_match     = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
    assign hazard        = ex_is_load_wb & id_valid & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble counter and a flush that survives MEM stalls.
// Handshake: id_ready=1 means the ID instruction is consumed at this edge; 0 means IF/ID holds.
module id_ex_stage #(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int CSR_AW       = riscv_pkg::CSR_AW,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               id_valid,
    input  logic [XLEN-1:0]                    id_pc,
    input  logic [riscv_pkg::REG_AW-1:0]       id_rs1,
    input  logic [riscv_pkg::REG_AW-1:0]       id_rs2,
    input  logic                               id_use_rs1,
    input  logic                               id_use_rs2,
    input  logic [riscv_pkg::REG_AW-1:0]       id_rd,
    input  logic [XLEN-1:0]                    id_rs1_data,
    input  logic [XLEN-1:0]                    id_rs2_data,
    input  logic [XLEN-1:0]                    id_imm,
    input  logic [riscv_pkg::ALU_OP_W-1:0]     id_alu_op,
    input  logic                               id_wb,
    input  logic                               id_mem_read,
    input  logic                               id_mem_write,
    input  logic [CSR_AW-1:0]                  id_csr_addr,
    input  logic                               id_csr_wen,
    input  logic                               flush,
    input  logic                               mem_stall,
    output logic                               id_ready,
    output logic                               ex_valid,
    output logic [XLEN-1:0]                    ex_pc,
    output logic [riscv_pkg::REG_AW-1:0]       ex_rs1,
    output logic [riscv_pkg::REG_AW-1:0]       ex_rs2,
    output logic [riscv_pkg::REG_AW-1:0]       ex_rd,
    output logic [XLEN-1:0]                    ex_rs1_data,
    output logic [XLEN-1:0]                    ex_rs2_data,
    output logic [XLEN-1:0]                    ex_imm,
    output logic [riscv_pkg::ALU_OP_W-1:0]     ex_alu_op,
    output logic                               ex_wb,
    output logic                               ex_mem_read,
    output logic                               ex_mem_write,
    output logic [CSR_AW-1:0]                  ex_csr_addr,
    output logic                               ex_csr_wen,
    output logic [1:0]                         dbg_bubble_cnt,
    output logic                               dbg_flush_pend
);
    import riscv_pkg::*;

    // Bubbles still owed after the one loaded on the hazard edge.
    localparam logic [1:0] RELOAD = 2'(LOAD_BUBBLES - 1);

    logic       hazard;
    logic [1:0] bubble_cnt, bubble_cnt_nxt;
    logic       flush_pend, flush_pend_nxt;
    ex_action_e action;

    load_use_detect u_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_wb       (ex_wb),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .hazard      (hazard)
    );

    assign id_ready       = ~mem_stall & ~hazard & (bubble_cnt == 2'd0) & ~(flush | flush_pend);
    assign dbg_bubble_cnt = bubble_cnt;
    assign dbg_flush_pend = flush_pend;

    always_comb begin
        action         = ACT_CAPTURE;
        bubble_cnt_nxt = bubble_cnt;
        flush_pend_nxt = flush_pend;
        if (mem_stall) begin
            action = ACT_HOLD;
            if (flush) flush_pend_nxt = 1'b1;
        end else if (flush | flush_pend) begin
            action         = ACT_BUBBLE;
            flush_pend_nxt = 1'b0;
            bubble_cnt_nxt = 2'd0;
        end else if (bubble_cnt != 2'd0) begin
            action         = ACT_BUBBLE;
            bubble_cnt_nxt = bubble_cnt - 2'd1;
        end else if (hazard) begin
            action         = ACT_BUBBLE;
            bubble_cnt_nxt = RELOAD;
        end else if (!id_valid) begin
            action = ACT_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= 2'd0;
            flush_pend <= 1'b0;
        end else begin
            bubble_cnt <= bubble_cnt_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1       <= REG_X0;
            ex_rs2       <= REG_X0;
            ex_rd        <= REG_X0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_alu_op    <= '0;
            ex_wb        <= BUBBLE_WB_N;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_csr_addr  <= '0;
            ex_csr_wen   <= BUBBLE_CSR_WEN_N;
        end else begin
            case (action)
                ACT_BUBBLE: begin
                    ex_valid     <= 1'b0;
                    ex_pc        <= '0;
                    ex_rs1       <= REG_X0;
                    ex_rs2       <= REG_X0;
                    ex_rd        <= REG_X0;
                    ex_rs1_data  <= '0;
                    ex_rs2_data  <= '0;
                    ex_imm       <= '0;
                    ex_alu_op    <= '0;
                    ex_wb        <= BUBBLE_WB_N;
                    ex_mem_read  <= 1'b0;
                    ex_mem_write <= 1'b0;
                    ex_csr_addr  <= '0;
                    ex_csr_wen   <= BUBBLE_CSR_WEN_N;
                end
                ACT_CAPTURE: begin
                    ex_valid     <= 1'b1;
                    ex_pc        <= id_pc;
                    ex_rs1       <= id_rs1;
                    ex_rs2       <= id_rs2;
                    ex_rd        <= id_rd;
                    ex_rs1_data  <= id_rs1_data;
                    ex_rs2_data  <= id_rs2_data;
                    ex_imm       <= id_imm;
                    ex_alu_op    <= id_alu_op;
                    ex_wb        <= id_wb;
                    ex_mem_read  <= id_mem_read;
                    ex_mem_write <= id_mem_write;
                    ex_csr_addr  <= id_csr_addr;
                    ex_csr_wen   <= id_csr_wen;
                end
                default: ;
            endcase
        end
    end

endmodule
